poly_mul_seq_ctrl: RTL and testbench

//  Host-side command sequencer for top_poly_mul. It drives the core's conf opcode and consumes
//  its done_flag, so a program list of operations runs unattended (e.g. NTT 1 -> PWM 4 -> INTT 3/5).
//  It sits between the system control port and top_poly_mul and replaces ad-hoc conf driving.
//  Per step: issue opcode, hold it, wait for completion, insert a gap, advance.

---
 rtl/poly_mul_pkg.sv | 23 ++
 rtl/seq_timeout_cnt.sv | 32 +++
 rtl/poly_mul_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_poly_mul_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mul_pkg.sv
// Shared opcodes, FSM encoding and defaults for the
// poly_mul host-side command sequencer.
package poly_mul_pkg;

  localparam int OPW         = 3;
  localparam int MAX_OPS_DEF = 4;

  localparam logic [OPW-1:0] OP_IDLE  = 3'd0;
  localparam logic [OPW-1:0] OP_NTT   = 3'd1;
  localparam logic [OPW-1:0] OP_INTT  = 3'd3;
  localparam logic [OPW-1:0] OP_PWM   = 3'd4;
  localparam logic [OPW-1:0] OP_INTT2 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } seq_state_t;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Loadable up-counter with clear/enable; o_hit fires on the
// enabled cycle that brings the count to LIMIT.
module seq_timeout_cnt #(
  parameter int LIMIT = 4096,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;
  logic         w_at_lim;

  assign w_at_lim = (r_cnt == W'(LIMIT - 1));
  assign o_hit    = i_en & w_at_lim;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en && !w_at_lim) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/poly_mul_seq_ctrl.sv
// Command sequencer for top_poly_mul: issues each opcode of a
// latched program, waits for done_flag, gaps, then advances.
module poly_mul_seq_ctrl
  import poly_mul_pkg::*;
#(
  parameter int  MAX_OPS = MAX_OPS_DEF,
  parameter int  TIMEOUT = 4096,
  parameter int  GAP_CYC = 2,
  localparam int CW      = $clog2(MAX_OPS + 1),
  localparam int SW      = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OPW*MAX_OPS-1:0] op_list,
  input  logic [CW-1:0]          op_cnt,
  input  logic [OPW-1:0]         done_flag,
  output logic [OPW-1:0]         conf,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   err,
  output logic [SW-1:0]          step_idx,
  output logic [OPW-1:0]         last_code
);

  seq_state_t             r_state;
  logic [OPW*MAX_OPS-1:0] r_ops;
  logic [CW-1:0]          r_cnt;
  logic [OPW-1:0]         r_conf;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [SW-1:0]          r_step;
  logic [OPW-1:0]         r_code;

  logic                   w_to_hit;
  logic                   w_gap_hit;
  logic                   w_fin;
  logic                   w_last;
  logic [OPW-1:0]         w_op;
  logic [CW-1:0]          w_cnt;

  assign w_op   = r_ops[int'(r_step)*OPW +: OPW];
  assign w_fin  = (done_flag != OP_IDLE);
  assign w_last = ((CW'(r_step) + CW'(1)) == r_cnt);
  // Out-of-range counts are clamped so step_idx can never wrap.
  assign w_cnt  = (op_cnt > CW'(MAX_OPS)) ? CW'(MAX_OPS) : op_cnt;

  seq_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != S_WAIT),
    .i_en     (r_state == S_WAIT),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .o_hit    (w_to_hit)
  );

  seq_timeout_cnt #(
    .LIMIT (GAP_CYC)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != S_GAP),
    .i_en     (r_state == S_GAP),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .o_hit    (w_gap_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ops   <= '0;
      r_cnt   <= '0;
      r_conf  <= OP_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_step  <= '0;
      r_code  <= OP_IDLE;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_err  <= 1'b0;
            r_step <= '0;
            if (op_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_ops   <= op_list;
              r_cnt   <= w_cnt;
              r_busy  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_op == OP_IDLE) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_conf  <= w_op;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion outranks a timeout landing on the same cycle.
          if (w_fin) begin
            r_code <= done_flag;
            r_conf <= OP_IDLE;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_GAP;
            end
          end else if (w_to_hit) begin
            r_conf  <= OP_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end
        end
        S_GAP: begin
          if (w_gap_hit) begin
            r_step  <= r_step + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign conf      = r_conf;
  assign busy      = r_busy;
  assign seq_done  = r_done;
  assign err       = r_err;
  assign step_idx  = r_step;
  assign last_code = r_code;

endmodule

// File: tb/tb_poly_mul_seq_ctrl.sv
// Scoreboard bench for poly_mul_seq_ctrl: a program-level model
// predicts conf/seq_done/err events with their cycle times.
module tb_poly_mul_seq_ctrl;
  import poly_mul_pkg::*;

  localparam int MO  = 4;
  localparam int TO  = 4096;
  localparam int GAP = 2;
  localparam int CW  = $clog2(MO + 1);
  localparam int SW  = $clog2(MO);
  localparam int K_CONF = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct { int kind; int val; int step; int t; } ev_t;
  typedef struct { int d; int code; } core_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [3*MO-1:0] op_list = '0;
  logic [CW-1:0]   op_cnt = '0;
  logic [2:0]      done_flag = '0;
  logic [2:0]      conf;
  logic            busy;
  logic            seq_done;
  logic            err;
  logic [SW-1:0]   step_idx;
  logic [2:0]      last_code;

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    lc_model = 0;
  bit    junk = 1'b0;
  ev_t   exp_q[$];
  core_t core_q[$];

  poly_mul_seq_ctrl #(
    .MAX_OPS (MO),
    .TIMEOUT (TO),
    .GAP_CYC (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_list   (op_list),
    .op_cnt    (op_cnt),
    .done_flag (done_flag),
    .conf      (conf),
    .busy      (busy),
    .seq_done  (seq_done),
    .err       (err),
    .step_idx  (step_idx),
    .last_code (last_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void push(int kind, int val, int step, int t);
    ev_t e;
    e.kind = kind; e.val = val; e.step = step; e.t = t;
    exp_q.push_back(e);
  endfunction

  // Core model: completes each op d cycles after conf appears.
  int    ccnt = 0;
  bit    cact = 1'b0;
  core_t cur;
  always @(negedge clk) begin
    if (rst || conf == 3'd0) begin
      cact = 1'b0;
      ccnt = 0;
      done_flag = (junk && !rst) ? 3'($urandom_range(7)) : 3'd0;
    end else begin
      if (!cact) begin
        cact = 1'b1;
        if (core_q.size() > 0) cur = core_q.pop_front();
        else begin cur.d = 0; cur.code = 0; end
      end
      ccnt++;
      done_flag = (cur.d != 0 && ccnt == cur.d) ? 3'(cur.code) : 3'd0;
    end
  end

  function automatic void see(int kind, int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_val", val, e.val);
    chk("event_time", cyc, e.t);
    if (e.step >= 0) chk("event_step", int'(step_idx), e.step);
    chk("event_busy", int'(busy), (kind == K_CONF) ? 1 : 0);
    if (kind == K_DONE) chk("done_err_low", int'(err), 0);
    if (kind == K_ERR) chk("err_conf_zero", int'(conf), 0);
  endfunction

  // Monitor: pops the scoreboard on every DUT-visible event.
  logic [2:0] pconf = '0;
  logic       perr = 1'b0;
  int         zrun = -1;
  always @(negedge clk) begin
    if (rst) begin
      pconf = '0; perr = 1'b0; zrun = -1;
    end else begin
      if (pconf != 0 && conf != 0) chk("conf_stable", int'(conf), int'(pconf));
      if (conf != 0 && pconf == 0) begin
        if (zrun > 0) chk("gap_zero_run", zrun, GAP + 1);
        see(K_CONF, int'(conf));
      end
      if (seq_done) see(K_DONE, int'(last_code));
      if (err && !perr) see(K_ERR, int'(err));
      if (!busy) zrun = -1;
      else if (conf != 0) zrun = 0;
      else if (zrun >= 0) zrun++;
      pconf = conf;
      perr = err;
    end
  end

  task automatic issue_prog(input logic [3*MO-1:0] ops, input int cnt,
                            input int d[MO], input int code[MO]);
    int t;
    int tc;
    int op;
    @(negedge clk);
    op_list = ops;
    op_cnt = CW'(cnt);
    start = 1'b1;
    t = cyc;
    if (cnt == 0) begin
      push(K_DONE, lc_model, -1, t + 1);
    end else begin
      tc = t + 2;
      for (int k = 0; k < cnt; k++) begin
        op = int'(ops[3*k +: 3]);
        if (op == 0) begin
          push(K_ERR, 1, k, tc);
          break;
        end
        push(K_CONF, op, k, tc);
        core_q.push_back('{d[k], code[k]});
        if (d[k] == 0 || d[k] > TO) begin
          push(K_ERR, 1, k, tc + TO);
          break;
        end
        lc_model = code[k];
        if (k == cnt - 1) push(K_DONE, code[k], k, tc + d[k]);
        tc = tc + d[k] + GAP + 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    core_q.delete();
    repeat (GAP + 4) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_conf"}, int'(conf), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_seq_done"}, int'(seq_done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_step"}, int'(step_idx), 0);
    chk({tag, "_last_code"}, int'(last_code), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3*MO-1:0] ops;
    int d[MO];
    int c[MO];
    int cnt;
    int optab[4];
    optab = '{int'(OP_NTT), int'(OP_INTT), int'(OP_PWM), int'(OP_INTT2)};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two ops, both finishing after 1280 cycles.
    ops = {3'd0, 3'd0, OP_PWM, OP_NTT};
    d = '{1280, 1280, 0, 0};
    c = '{1, 1, 0, 0};
    issue_prog(ops, 2, d, c);
    drain(4000);
    chk("s1_last_code", int'(last_code), 1);
    chk("s1_err", int'(err), 0);

    // Core never answers: timeout abort.
    ops = {3'd0, 3'd0, 3'd0, OP_NTT};
    d = '{0, 0, 0, 0};
    c = '{0, 0, 0, 0};
    issue_prog(ops, 1, d, c);
    drain(TO + 100);
    chk("s2_err", int'(err), 1);
    chk("s2_busy", int'(busy), 0);
    chk("s2_conf", int'(conf), 0);

    // Reset while step 1 waits, then a clean rerun.
    ops = {3'd0, 3'd0, OP_INTT, OP_NTT};
    d = '{10, 500, 0, 0};
    c = '{2, 3, 0, 0};
    issue_prog(ops, 2, d, c);
    repeat (40) @(negedge clk);
    chk("s3_mid_step", int'(step_idx), 1);
    chk("s3_mid_conf", int'(conf), int'(OP_INTT));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("s3_rst");
    exp_q.delete();
    core_q.delete();
    lc_model = 0;
    rst = 1'b0;
    ops = {3'd0, 3'd0, OP_INTT2, OP_INTT};
    d = '{7, 9, 0, 0};
    c = '{4, 6, 0, 0};
    issue_prog(ops, 2, d, c);
    drain(200);

    // Start pulse while busy must be ignored.
    ops = {3'd0, OP_INTT, OP_PWM, OP_NTT};
    d = '{30, 30, 30, 0};
    c = '{1, 2, 3, 0};
    issue_prog(ops, 3, d, c);
    repeat (10) @(negedge clk);
    op_list = {3'd0, 3'd0, 3'd0, OP_INTT2};
    op_cnt = CW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("s4_step", int'(step_idx), 0);
    chk("s4_conf", int'(conf), int'(OP_NTT));
    chk("s4_busy", int'(busy), 1);
    drain(300);

    // Empty program: only a seq_done pulse.
    issue_prog('0, 0, d, c);
    drain(20);
    chk("s4_empty_busy", int'(busy), 0);

    // Zero opcode at step 1 aborts after step 0 completes.
    ops = {3'd0, 3'd0, 3'd0, OP_INTT};
    d = '{12, 0, 0, 0};
    c = '{5, 0, 0, 0};
    issue_prog(ops, 2, d, c);
    drain(200);
    chk("s5_err", int'(err), 1);
    chk("s5_last_code", int'(last_code), 5);

    // Completion on the exact timeout cycle wins.
    ops = {3'd0, 3'd0, OP_PWM, OP_NTT};
    d = '{TO, 6, 0, 0};
    c = '{2, 2, 0, 0};
    issue_prog(ops, 2, d, c);
    drain(TO + 200);
    chk("s6_err", int'(err), 0);
    chk("s6_last_code", int'(last_code), 2);

    // Random programs with noise on done_flag outside WAIT.
    junk = 1'b1;
    for (int it = 0; it < 14; it++) begin
      cnt = $urandom_range(MO, 0);
      ops = '0;
      for (int k = 0; k < MO; k++) begin
        ops[3*k +: 3] = ($urandom_range(7) == 0) ? 3'd0 : 3'(optab[$urandom_range(3)]);
        d[k] = $urandom_range(40, 1);
        c[k] = $urandom_range(7, 1);
      end
      issue_prog(ops, cnt, d, c);
      drain(600);
    end
    junk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
